hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 39 +++
 rtl/hazard_ctrl_slot.sv | 28 ++
 rtl/hazard_ctrl.sv | 85 ++++++++
 tb/tb_hazard_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings and slot layout for the decode-stage hazard/forwarding controller.
// Imported by id_stage so the forwarding mux agrees with the select codes.
package hazard_ctrl_pkg;

    localparam int REG_W     = 5;
    localparam int CNT_W     = 16;
    localparam int NUM_SLOTS = 3;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_ES = 2'b01,
        FWD_MS = 2'b10,
        FWD_WS = 2'b11
    } fwd_sel_e;

    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] dest;
        logic             ld;
    } slot_t;

    // $0 is hard-wired, so a slot naming it never produces a value worth forwarding.
    function automatic logic slot_hit(input logic v, input logic [REG_W-1:0] dest,
                                      input logic [REG_W-1:0] src);
        return v && (dest != '0) && (dest == src);
    endfunction

    function automatic logic [1:0] fwd_encode(input logic used, input logic [NUM_SLOTS-1:0] hit);
        logic [1:0] sel;
        sel = FWD_RF;
        if (used) begin
            if (hit[0])      sel = FWD_ES;
            else if (hit[1]) sel = FWD_MS;
            else if (hit[2]) sel = FWD_WS;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_ctrl_slot.sv
// One shadow {v,dest,ld} register tracking the instruction held by a pipeline stage.
// Load wins over clear so a simultaneous refill and drain keeps the incoming entry.
module hazard_slot
    import hazard_ctrl_pkg::*;
(
    input  logic  clk,
    input  logic  resetn,
    input  logic  load,
    input  logic  clear,
    input  slot_t d,
    output slot_t q
);

    slot_t q_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q_reg <= '0;
        end else if (load) begin
            q_reg <= d;
        end else if (clear) begin
            q_reg.v <= 1'b0;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/hazard_ctrl.sv
// Tracks destinations in EX/MEM/WB, picks the forwarding source for each decode
// operand and stalls decode when it needs a load result still sitting in EX.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             ds_valid,
    input  logic [REG_W-1:0] ds_rs,
    input  logic [REG_W-1:0] ds_rt,
    input  logic             ds_rs_used,
    input  logic             ds_rt_used,
    input  logic [REG_W-1:0] ds_dest,
    input  logic             ds_gr_we,
    input  logic             ds_load_op,
    input  logic             ds_fire,
    input  logic             es_fire,
    input  logic             ms_fire,
    input  logic             ws_fire,
    output logic [1:0]       rs_fwd_sel,
    output logic [1:0]       rt_fwd_sel,
    output logic             load_stall,
    output logic [CNT_W-1:0] stall_cnt
);

    slot_t                slot_q [NUM_SLOTS];
    slot_t                slot_d [NUM_SLOTS];
    slot_t                ds_slot;
    logic [NUM_SLOTS:0]   fire;
    logic [NUM_SLOTS-1:0] rs_hit;
    logic [NUM_SLOTS-1:0] rt_hit;
    logic [CNT_W-1:0]     stall_cnt_reg;
    logic [CNT_W-1:0]     stall_cnt_next;
    logic                 unused_ws_ld;

    assign fire    = {ws_fire, ms_fire, es_fire, ds_fire};
    assign ds_slot = '{v: ds_gr_we && (ds_dest != '0), dest: ds_dest, ld: ds_load_op};

    // Slot gi loads from its upstream on fire[gi] and drains on fire[gi+1],
    // so all fires in one edge shift the whole chain by one stage.
    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            if (gi == 0) begin : g_head
                assign slot_d[gi] = ds_slot;
            end else begin : g_body
                assign slot_d[gi] = slot_q[gi-1];
            end

            hazard_slot u_slot (
                .clk    (clk),
                .resetn (resetn),
                .load   (fire[gi]),
                .clear  (fire[gi+1]),
                .d      (slot_d[gi]),
                .q      (slot_q[gi])
            );

            assign rs_hit[gi] = slot_hit(slot_q[gi].v, slot_q[gi].dest, ds_rs);
            assign rt_hit[gi] = slot_hit(slot_q[gi].v, slot_q[gi].dest, ds_rt);
        end
    endgenerate

    assign unused_ws_ld = slot_q[NUM_SLOTS-1].ld;

    assign rs_fwd_sel = fwd_encode(ds_rs_used, rs_hit);
    assign rt_fwd_sel = fwd_encode(ds_rt_used, rt_hit);

    // Only a load in EX stalls; from MEM onward the loaded value is forwardable.
    assign load_stall = ds_valid && slot_q[0].ld &&
                        ((ds_rs_used && rs_hit[0]) || (ds_rt_used && rt_hit[0]));

    assign stall_cnt_next = (load_stall && (stall_cnt_reg != '1)) ?
                            stall_cnt_reg + CNT_W'(1) : stall_cnt_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt_reg <= '0;
        end else begin
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl: stimulus queues expected outputs,
// a negedge monitor pops and compares them one transaction per line.
module tb_hazard_ctrl;

    typedef struct packed {
        logic [1:0]  rs_sel;
        logic [1:0]  rt_sel;
        logic        stall;
        logic [15:0] cnt;
    } exp_t;

    logic        clk;
    logic        resetn;
    logic        ds_valid;
    logic [4:0]  ds_rs;
    logic [4:0]  ds_rt;
    logic        ds_rs_used;
    logic        ds_rt_used;
    logic [4:0]  ds_dest;
    logic        ds_gr_we;
    logic        ds_load_op;
    logic        ds_fire;
    logic        es_fire;
    logic        ms_fire;
    logic        ws_fire;
    logic [1:0]  rs_fwd_sel;
    logic [1:0]  rt_fwd_sel;
    logic        load_stall;
    logic [15:0] stall_cnt;

    exp_t  exp_q [$];
    string name_q [$];
    int    errors = 0;
    int    checks = 0;
    logic  done   = 1'b0;

    hazard_ctrl dut (
        .clk        (clk),
        .resetn     (resetn),
        .ds_valid   (ds_valid),
        .ds_rs      (ds_rs),
        .ds_rt      (ds_rt),
        .ds_rs_used (ds_rs_used),
        .ds_rt_used (ds_rt_used),
        .ds_dest    (ds_dest),
        .ds_gr_we   (ds_gr_we),
        .ds_load_op (ds_load_op),
        .ds_fire    (ds_fire),
        .es_fire    (es_fire),
        .ms_fire    (ms_fire),
        .ws_fire    (ws_fire),
        .rs_fwd_sel (rs_fwd_sel),
        .rt_fwd_sel (rt_fwd_sel),
        .load_stall (load_stall),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ds_valid = 0; ds_rs = 0; ds_rt = 0; ds_rs_used = 0; ds_rt_used = 0;
        ds_dest = 0; ds_gr_we = 0; ds_load_op = 0;
        ds_fire = 0; es_fire = 0; ms_fire = 0; ws_fire = 0;
    endtask

    task automatic issue(input logic [4:0] dest, input logic we, input logic ld);
        ds_fire = 1; ds_dest = dest; ds_gr_we = we; ds_load_op = ld;
    endtask

    task automatic rd(input logic [4:0] rs, input logic rsu, input logic [4:0] rt, input logic rtu);
        ds_valid = 1; ds_rs = rs; ds_rs_used = rsu; ds_rt = rt; ds_rt_used = rtu;
    endtask

    task automatic fires(input logic e, input logic m, input logic w);
        es_fire = e; ms_fire = m; ws_fire = w;
    endtask

    task automatic expect_out(input string nm, input logic [1:0] rs, input logic [1:0] rt,
                              input logic st, input logic [15:0] cnt);
        exp_q.push_back('{rs_sel: rs, rt_sel: rt, stall: st, cnt: cnt});
        name_q.push_back(nm);
    endtask

    task automatic flush();
        repeat (3) begin
            tick(); idle(); fires(1, 1, 1);
        end
        tick(); idle();
    endtask

    task automatic cmp(input string nm, input string fld, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s %s got=%0h want=%0h", nm, fld, got, want);
        end
    endtask

    // Monitor: the DUT presents outputs every cycle; compare whenever one is expected.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                cmp(nm, "rs_fwd_sel", int'(rs_fwd_sel), int'(e.rs_sel));
                cmp(nm, "rt_fwd_sel", int'(rt_fwd_sel), int'(e.rt_sel));
                cmp(nm, "load_stall", int'(load_stall), int'(e.stall));
                cmp(nm, "stall_cnt",  int'(stall_cnt),  int'(e.cnt));
                $display("txn %-16s rs=%0d rt=%0d stall=%0d cnt=%0h", nm,
                         rs_fwd_sel, rt_fwd_sel, load_stall, stall_cnt);
            end
            if (done && exp_q.size() == 0) begin
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Busy inputs while reset is held must not reach the slots.
        idle();
        resetn = 0;
        issue(5'd3, 1, 0); rd(5'd3, 1, 5'd3, 1); fires(1, 1, 1);
        tick(); expect_out("rst_hold_a", 2'b00, 2'b00, 0, 16'h0);
        tick(); expect_out("rst_hold_b", 2'b00, 2'b00, 0, 16'h0);
        tick(); idle(); resetn = 1;
        expect_out("post_rst", 2'b00, 2'b00, 0, 16'h0);

        // ALU result walks EX -> MEM -> WB -> gone
        tick(); idle(); issue(5'd3, 1, 0);
        expect_out("addu_issue", 2'b00, 2'b00, 0, 16'h0);
        tick(); idle(); rd(5'd3, 1, 5'd0, 0); fires(1, 1, 1);
        expect_out("fwd_es", 2'b01, 2'b00, 0, 16'h0);
        tick(); expect_out("fwd_ms", 2'b10, 2'b00, 0, 16'h0);
        tick(); expect_out("fwd_ws", 2'b11, 2'b00, 0, 16'h0);
        tick(); expect_out("fwd_none", 2'b00, 2'b00, 0, 16'h0);

        // Load-use: one stall cycle, then MEM forward
        tick(); idle(); issue(5'd5, 1, 1);
        expect_out("lw_issue", 2'b00, 2'b00, 0, 16'h0);
        tick(); idle(); rd(5'd0, 0, 5'd5, 1); fires(1, 0, 0);
        expect_out("lw_stall", 2'b00, 2'b01, 1, 16'h0);
        tick(); idle(); rd(5'd5, 0, 5'd5, 1);
        expect_out("lw_after", 2'b00, 2'b10, 0, 16'h1);
        flush();

        // $7 in ES and WS, $9 in MS
        issue(5'd7, 1, 0);
        tick(); idle(); issue(5'd9, 1, 0); fires(1, 0, 0);
        tick(); idle(); issue(5'd7, 1, 0); fires(1, 1, 0);
        tick(); idle(); rd(5'd7, 1, 5'd9, 1);
        expect_out("es_priority", 2'b01, 2'b10, 0, 16'h1);
        flush();

        // Writer of $0 never forwards or stalls
        issue(5'd0, 1, 1);
        tick(); idle(); rd(5'd0, 1, 5'd0, 1);
        expect_out("dest0", 2'b00, 2'b00, 0, 16'h1);
        flush();

        // All four fires in one edge shift the chain
        issue(5'd3, 1, 0);
        tick(); idle(); issue(5'd2, 1, 0); fires(1, 0, 0);
        tick(); idle(); issue(5'd1, 1, 0); fires(1, 1, 0);
        tick(); idle(); rd(5'd3, 1, 5'd2, 1); issue(5'd4, 1, 0); fires(1, 1, 1);
        expect_out("pre_shift", 2'b11, 2'b10, 0, 16'h1);
        tick(); idle(); rd(5'd3, 1, 5'd1, 1);
        expect_out("shift_a", 2'b00, 2'b10, 0, 16'h1);
        tick(); idle(); rd(5'd4, 1, 5'd2, 1);
        expect_out("shift_b", 2'b01, 2'b11, 0, 16'h1);
        flush();

        // ds_fire during a stall is honoured and the stall still counts
        issue(5'd6, 1, 1);
        tick(); idle(); rd(5'd6, 1, 5'd0, 0); issue(5'd8, 1, 0);
        expect_out("stall_fire", 2'b01, 2'b00, 1, 16'h1);
        tick(); idle(); rd(5'd8, 1, 5'd6, 1);
        expect_out("stall_fire_after", 2'b01, 2'b00, 0, 16'h2);
        flush();

        // Saturation: hold a load-use stall until the counter tops out
        issue(5'd10, 1, 1);
        tick(); idle(); rd(5'd10, 1, 5'd0, 0);
        expect_out("sat_start", 2'b01, 2'b00, 1, 16'h2);
        repeat (65531) @(posedge clk);
        tick(); expect_out("sat_fffe", 2'b01, 2'b00, 1, 16'hFFFE);
        tick(); expect_out("sat_ffff_a", 2'b01, 2'b00, 1, 16'hFFFF);
        tick(); expect_out("sat_ffff_b", 2'b01, 2'b00, 1, 16'hFFFF);

        // Asynchronous reset mid-stall, checked before the next clock edge
        tick(); expect_out("async_rst", 2'b00, 2'b00, 0, 16'h0);
        #2 resetn = 0;
        tick(); resetn = 1;
        expect_out("rst_discard", 2'b00, 2'b00, 0, 16'h0);

        tick();
        done = 1'b1;
    end

endmodule
